// File: rtl/jtframe_rq_arb.sv
// Three-slot round-robin arbiter in front of a single-port SDRAM controller.
// One transaction in flight at a time, guarded by a watchdog that fakes a reply on timeout.
module jtframe_rq_arb #(
  parameter int TOUT = 255
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [2:0]  slot_req,
  input  logic [2:0]  slot_rnw,
  input  logic [65:0] slot_addr,
  input  logic [47:0] slot_wrdata,
  output logic [2:0]  slot_we,
  output logic        data_rdy,
  output logic [31:0] data_read,
  output logic        sdram_req,
  output logic        sdram_rnw,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_din,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_dout,
  output logic        tout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY, RET} state_t;

  state_t      r_st, w_st_nxt;
  logic [1:0]  r_ptr;
  logic [2:0]  r_gnt;
  logic [7:0]  r_wd;
  logic [1:0]  w_ord [3];
  logic [2:0]  w_gnt;
  logic [21:0] w_addr;
  logic        w_rnw;
  logic [15:0] w_din;
  logic        w_grant, w_done, w_tout, w_wd_max;

  assign w_wd_max = (r_wd == 8'(TOUT - 1));

  // Search order starts at r_ptr; the lowest position in the order wins.
  always_comb begin
    w_ord[0] = r_ptr;
    w_ord[1] = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_ord[2] = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
    w_gnt    = '0;
    for (int k = 2; k >= 0; k--)
      if (slot_req[w_ord[k]]) w_gnt = 3'b001 << w_ord[k];
    w_addr = '0;
    w_rnw  = 1'b1;
    w_din  = '0;
    for (int j = 0; j < 3; j++)
      if (w_gnt[j]) begin
        w_addr = slot_addr[22*j +: 22];
        w_rnw  = slot_rnw[j];
        w_din  = slot_wrdata[16*j +: 16];
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= IDLE;
    else     r_st <= w_st_nxt;

  // ack+rdy together skips WAIT_RDY; a real reply beats the watchdog on the same edge.
  always_comb begin
    w_st_nxt = r_st;
    w_grant  = 1'b0;
    w_done   = 1'b0;
    w_tout   = 1'b0;
    case (r_st)
      IDLE: if (|slot_req) begin
        w_grant  = 1'b1;
        w_st_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (sdram_ack && sdram_rdy) begin
          w_done   = 1'b1;
          w_st_nxt = RET;
        end else if (sdram_ack) begin
          w_st_nxt = WAIT_RDY;
        end else if (w_wd_max) begin
          w_tout   = 1'b1;
          w_st_nxt = RET;
        end
      end
      WAIT_RDY: begin
        if (sdram_rdy) begin
          w_done   = 1'b1;
          w_st_nxt = RET;
        end else if (w_wd_max) begin
          w_tout   = 1'b1;
          w_st_nxt = RET;
        end
      end
      RET:     w_st_nxt = IDLE;
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_wd       <= '0;
      sdram_req  <= 1'b0;
      sdram_rnw  <= 1'b1;
      sdram_addr <= '0;
      sdram_din  <= '0;
      data_rdy   <= 1'b0;
      data_read  <= '0;
      slot_we    <= '0;
      tout_err   <= 1'b0;
    end else begin
      data_rdy <= 1'b0;
      slot_we  <= '0;
      if (r_st == WAIT_ACK || r_st == WAIT_RDY) r_wd <= r_wd + 8'd1;
      if (r_st == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
      if (w_grant) begin
        r_gnt      <= w_gnt;
        r_ptr      <= w_gnt[0] ? 2'd1 : (w_gnt[1] ? 2'd2 : 2'd0);
        r_wd       <= '0;
        sdram_req  <= 1'b1;
        sdram_rnw  <= w_rnw;
        sdram_addr <= w_addr;
        sdram_din  <= w_din;
      end
      if (w_done) begin
        data_read <= sdram_dout;
        data_rdy  <= 1'b1;
        slot_we   <= r_gnt;
      end
      if (w_tout) begin
        sdram_req <= 1'b0;
        tout_err  <= 1'b1;
        data_read <= '1;
        data_rdy  <= 1'b1;
        slot_we   <= r_gnt;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_rq_arb.sv
// Randomised + directed bench for jtframe_rq_arb: slot drivers, SDRAM responder with
// a round-robin reference, and a data_rdy monitor popping an expected-response queue.
module tb_jtframe_rq_arb;
  localparam int TOUT = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  slot_req = '0, slot_rnw = '0;
  logic [65:0] slot_addr = '0;
  logic [47:0] slot_wrdata = '0;
  logic [2:0]  slot_we;
  logic        data_rdy, sdram_req, sdram_rnw, tout_err;
  logic [31:0] data_read, sdram_dout;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic        sdram_ack, sdram_rdy;

  always #5 clk = ~clk;

  jtframe_rq_arb #(.TOUT(TOUT)) dut (
    .rst(rst), .clk(clk), .slot_req(slot_req), .slot_rnw(slot_rnw),
    .slot_addr(slot_addr), .slot_wrdata(slot_wrdata), .slot_we(slot_we),
    .data_rdy(data_rdy), .data_read(data_read), .sdram_req(sdram_req),
    .sdram_rnw(sdram_rnw), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout),
    .tout_err(tout_err)
  );

  typedef struct { logic [2:0] we; logic [31:0] data; } resp_t;

  int          checks = 0, errors = 0;
  resp_t       exp_q[$];
  logic [2:0]  served[$];
  resp_t       m_e;
  int          done_cnt[3] = '{0, 0, 0};
  logic [2:0]  pend = '0, pend_q = '0;
  logic [21:0] a_addr[3];
  logic        a_rnw[3];
  logic [15:0] a_wd[3];
  int          mode = 0;           // 0 normal, 1 never ack, 2 ack then stall
  logic        spur_en = 0, same_cyc = 0, fix_en = 0, stalled = 0, stall_rel = 0;
  int          fix_ack = 0, fix_rdy = 0;
  logic [31:0] fix_dout = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) pend_q <= pend;

  // Monitor: every data_rdy pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (data_rdy) begin
      served.push_back(slot_we);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdy_unexpected slot_we %b want no pulse", slot_we);
      end else begin
        m_e = exp_q.pop_front();
        chk("slot_we", 64'(slot_we), 64'(m_e.we));
        chk("data_read", 64'(data_read), 64'(m_e.data));
        for (int j = 0; j < 3; j++) if (m_e.we[j]) done_cnt[j]++;
      end
    end else if (!rst) begin
      chk("slot_we_quiet", 64'(slot_we), 64'd0);
    end
  end

  // SDRAM responder; the expected owner comes from round-robin over pending slots.
  initial begin : sdram_model
    int g, ls, ackd, rdyd;
    logic [31:0] d;
    resp_t r;
    ls = 2;
    sdram_ack = 0; sdram_rdy = 0; sdram_dout = '0;
    forever begin
      @(negedge clk);
      if (rst) begin ls = 2; continue; end
      if (!sdram_req) begin
        if (mode == 0 && spur_en && $urandom_range(0, 5) == 0) begin
          sdram_rdy = 1; sdram_ack = 1'($urandom_range(0, 1)); sdram_dout = $urandom;
          @(posedge clk); #1 sdram_rdy = 0; sdram_ack = 0;
        end
        continue;
      end
      g = -1;
      for (int k = 1; k <= 3; k++)
        if (g < 0 && pend_q[(ls + k) % 3]) g = (ls + k) % 3;
      if (g < 0) begin
        checks++; errors++;
        $display("FAIL grant_none pending %b want no grant", pend_q);
        g = 0;
      end
      ls = g;
      chk("grant_addr", 64'(sdram_addr), 64'(a_addr[g]));
      chk("grant_rnw", 64'(sdram_rnw), 64'(a_rnw[g]));
      chk("grant_din", 64'(sdram_din), 64'(a_wd[g]));
      r.we = 3'b001 << g;
      if (mode == 1) begin
        r.data = 32'hFFFF_FFFF;
        exp_q.push_back(r);
        repeat (TOUT - 1) begin
          @(negedge clk);
          chk("wd_req_held", 64'(sdram_req), 64'd1);
          chk("wd_no_rdy", 64'(data_rdy), 64'd0);
        end
        @(negedge clk);
        chk("wd_req_cleared", 64'(sdram_req), 64'd0);
        chk("wd_tout_err", 64'(tout_err), 64'd1);
        chk("wd_rdy_pulse", 64'(data_rdy), 64'd1);
        @(negedge clk);
        chk("wd_rdy_single", 64'(data_rdy), 64'd0);
      end else if (mode == 2) begin
        #1 sdram_ack = 1;
        @(posedge clk); #1 sdram_ack = 0; stalled = 1;
        for (int i = 0; i < 200 && !stall_rel; i++) @(negedge clk);
        stalled = 0; ls = 2;
      end else begin
        if (spur_en && $urandom_range(0, 1) == 1) begin
          slot_addr[g*22 +: 22]   = 22'($urandom);
          slot_wrdata[g*16 +: 16] = 16'($urandom);
          slot_rnw[g]             = ~slot_rnw[g];
          if ($urandom_range(0, 1) == 1) slot_req[g] = 1'b0;
        end
        ackd = fix_en ? fix_ack : $urandom_range(0, 2);
        rdyd = fix_en ? fix_rdy : $urandom_range(0, 2);
        d    = fix_en ? fix_dout : $urandom;
        r.data = d;
        repeat (ackd) @(posedge clk);
        #1 sdram_ack = 1;
        if (same_cyc) begin
          sdram_rdy = 1; sdram_dout = d; exp_q.push_back(r);
          @(posedge clk); #1 sdram_ack = 0; sdram_rdy = 0;
        end else begin
          @(posedge clk); #1 sdram_ack = 0;
          repeat (rdyd) @(posedge clk);
          chk("frozen_addr", 64'(sdram_addr), 64'(a_addr[g]));
          chk("frozen_rnw", 64'(sdram_rnw), 64'(a_rnw[g]));
          chk("frozen_din", 64'(sdram_din), 64'(a_wd[g]));
          #1 sdram_rdy = 1; sdram_dout = d; exp_q.push_back(r);
          @(posedge clk); #1 sdram_rdy = 0; sdram_dout = $urandom;
        end
        @(negedge clk);
        chk("rdy_latency", 64'(data_rdy), 64'd1);
        @(negedge clk);
        chk("rdy_single", 64'(data_rdy), 64'd0);
      end
    end
  end

  // One request from slot n; call #1 after a rising edge. Holds req one cycle past data_rdy.
  task automatic do_req(int n, logic rnw, logic [21:0] addr, logic [15:0] wd);
    int start;
    start = done_cnt[n];
    a_addr[n] = addr; a_rnw[n] = rnw; a_wd[n] = wd;
    slot_addr[n*22 +: 22] = addr; slot_rnw[n] = rnw; slot_wrdata[n*16 +: 16] = wd;
    slot_req[n] = 1'b1; pend[n] = 1'b1;
    for (int i = 0; i < 100 && done_cnt[n] == start; i++) begin
      @(negedge clk); #1;
    end
    chk("slot_served", 64'(done_cnt[n] != start), 64'd1);
    pend[n] = 1'b0;
    @(posedge clk); #1 slot_req[n] = 1'b0;
  endtask

  task automatic rand_slot(int n, int cnt);
    for (int c = 0; c < cnt; c++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      @(posedge clk); #1;
      do_req(n, 1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom));
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_req"}, 64'(sdram_req), 64'd0);
    chk({tag, "_rdy"}, 64'(data_rdy), 64'd0);
    chk({tag, "_we"}, 64'(slot_we), 64'd0);
    chk({tag, "_tout"}, 64'(tout_err), 64'd0);
    chk({tag, "_data"}, 64'(data_read), 64'd0);
    chk({tag, "_addr"}, 64'(sdram_addr), 64'd0);
    chk({tag, "_rnw"}, 64'(sdram_rnw), 64'd1);
    chk({tag, "_din"}, 64'(sdram_din), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); chk_reset("rst0");
    @(posedge clk); #1 rst = 0;

    // Single read from slot 1 with fixed handshake timing.
    fix_en = 1; fix_ack = 1; fix_rdy = 2; fix_dout = 32'hCAFE_BABE;
    served.delete();
    do_req(1, 1'b1, 22'h1234, 16'h0000);
    fix_en = 0;
    chk("read1_count", 64'(served.size()), 64'd1);

    // Three simultaneous requests right after reset, two rounds.
    pulse_reset();
    served.delete();
    for (int rnd = 0; rnd < 2; rnd++) begin
      fork
        do_req(0, 1'b1, 22'h0000A0, 16'h1111);
        do_req(1, 1'b0, 22'h0000B1, 16'h2222);
        do_req(2, 1'b1, 22'h0000C2, 16'h3333);
      join
    end
    chk("rr_count", 64'(served.size()), 64'd6);
    for (int i = 0; i < 6 && i < served.size(); i++)
      chk("rr_order", 64'(served[i]), 64'(3'b001 << (i % 3)));

    // Write from slot 2, req held one cycle past data_rdy: no second grant.
    served.delete();
    @(posedge clk); #1;
    do_req(2, 1'b0, 22'h3F0F0F, 16'hA55A);
    repeat (10) @(negedge clk);
    chk("no_regrant", 64'(served.size()), 64'd1);

    // ack and rdy on the same cycle.
    same_cyc = 1;
    @(posedge clk); #1;
    do_req(0, 1'b1, 22'h000777, 16'h0);
    same_cyc = 0;

    // Randomised traffic on all slots, with spurious strobes and input scrambling.
    spur_en = 1;
    fork
      rand_slot(0, 25);
      rand_slot(1, 25);
      rand_slot(2, 25);
    join
    spur_en = 0;
    repeat (4) @(posedge clk);

    // Watchdog: no ack ever.
    mode = 1;
    @(posedge clk); #1;
    do_req(0, 1'b1, 22'h0BAD00, 16'h0);
    mode = 0;
    repeat (3) @(negedge clk);
    chk("tout_sticky", 64'(tout_err), 64'd1);

    // Reset while waiting for rdy.
    mode = 2;
    served.delete();
    @(posedge clk); #1;
    a_addr[1] = 22'h2AAAAA; a_rnw[1] = 1'b1; a_wd[1] = 16'h5555;
    slot_addr[22 +: 22] = 22'h2AAAAA; slot_rnw[1] = 1'b1; slot_wrdata[16 +: 16] = 16'h5555;
    slot_req[1] = 1'b1; pend[1] = 1'b1;
    for (int i = 0; i < 50 && !stalled; i++) @(negedge clk);
    chk("stall_reached", 64'(stalled), 64'd1);
    @(posedge clk); #1 rst = 1; slot_req[1] = 1'b0; pend[1] = 1'b0;
    @(negedge clk); chk_reset("rst1");
    @(posedge clk); #1 rst = 0;
    stall_rel = 1;
    for (int i = 0; i < 50 && stalled; i++) @(negedge clk);
    stall_rel = 0; mode = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_rdy", 64'(served.size()), 64'd0);
    @(posedge clk); #1;
    do_req(1, 1'b0, 22'h001357, 16'hBEEF);
    chk("post_rst_count", 64'(served.size()), 64'd1);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout time %0t want earlier finish", $time);
    $fatal(1);
  end
endmodule
